// File: rtl/snap_val_capture_ctrl.sv
// snap_val_capture_ctrl
// Single-word snapshot sequencer for a simulink2ppc readback register.
// Software arms the block, a software or external trigger starts a skip window of
// `delay` valid samples, and the next qualifying valid sample is latched into snap_out.
//
// Ports:
//   user_clk, user_rst_n    sole clock; asynchronous active-low reset
//   ctrl_arm                arm request level (rising edge acts)
//   ctrl_abort              level; forces IDLE while high
//   sw_trig, ext_trig       trigger levels (rising edge acts)
//   trig_sel                0 selects sw_trig, 1 selects ext_trig
//   delay                   valid samples to skip, sampled at the trigger
//   din, din_valid          sample stream and qualifier
//   snap_out                captured word
//   status                  {state, done, missed, zero pad, capture_count}
//   capture_pulse           one-cycle strobe when snap_out updates
module snap_val_capture_ctrl #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DELAY_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   user_clk,
  input  logic                   user_rst_n,
  input  logic                   ctrl_arm,
  input  logic                   ctrl_abort,
  input  logic                   sw_trig,
  input  logic                   ext_trig,
  input  logic                   trig_sel,
  input  logic [DELAY_WIDTH-1:0] delay,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   din_valid,
  output logic [DATA_WIDTH-1:0]  snap_out,
  output logic [31:0]            status,
  output logic                   capture_pulse
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StDelay = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [DELAY_WIDTH-1:0] DelayOne = DELAY_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  snap_q, snap_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   done_q, done_d;
  logic                   missed_q, missed_d;
  logic                   pulse_q;
  logic                   arm_q, sw_q, ext_q;

  logic                   arm_rise, sw_rise, ext_rise, trig;
  logic                   capture;
  logic                   in_window;
  logic [DELAY_WIDTH-1:0] win_cnt;
  logic [27:0]            count_ext;

  assign arm_rise = ctrl_arm & ~arm_q;
  assign sw_rise  = sw_trig & ~sw_q;
  assign ext_rise = ext_trig & ~ext_q;
  assign trig     = trig_sel ? ext_rise : sw_rise;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    missed_d  = missed_q;
    snap_d    = snap_q;
    count_d   = count_q;
    capture   = 1'b0;
    in_window = 1'b0;
    win_cnt   = cnt_q;

    if (ctrl_abort) begin
      // Abort wins over arm, trigger and any capture due this cycle.
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (arm_rise) begin
            state_d  = StArmed;
            done_d   = 1'b0;
            missed_d = 1'b0;
          end
        end
        StArmed: begin
          if (trig) begin
            // The trigger cycle counts as the first window cycle, using the fresh delay.
            state_d   = StDelay;
            in_window = 1'b1;
            win_cnt   = delay;
          end
        end
        StDelay: begin
          in_window = 1'b1;
          if (trig) begin
            missed_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (in_window) begin
      cnt_d = win_cnt;
      if (din_valid) begin
        if (win_cnt == '0) begin
          capture = 1'b1;
        end else begin
          cnt_d = win_cnt - DelayOne;
        end
      end
    end

    if (capture) begin
      state_d = StDone;
      done_d  = 1'b1;
      snap_d  = din;
      if (count_q != '1) begin
        count_d = count_q + CountOne;
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      snap_q   <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
      pulse_q  <= 1'b0;
      arm_q    <= 1'b0;
      sw_q     <= 1'b0;
      ext_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      count_q  <= count_d;
      done_q   <= done_d;
      missed_q <= missed_d;
      pulse_q  <= capture;
      arm_q    <= ctrl_arm;
      sw_q     <= sw_trig;
      ext_q    <= ext_trig;
    end
  end

  // The count field is zero-padded so status stays 32 bits for any legal COUNT_WIDTH.
  assign count_ext     = 28'(count_q);
  assign snap_out      = snap_q;
  assign capture_pulse = pulse_q;
  assign status        = {state_q, done_q, missed_q, count_ext};

endmodule

// File: tb/tb_snap_val_capture_ctrl.sv
// Self-checking bench for snap_val_capture_ctrl: directed scenarios followed by random
// stimulus. A behavioural model predicts each capture and pushes it into a scoreboard;
// a negedge monitor pops and compares whenever the DUT strobes capture_pulse.
// A second instance with a 2-bit capture counter exercises counter saturation.
module tb_snap_val_capture_ctrl;

  logic        clk = 1'b0;
  logic        user_rst_n;
  logic        ctrl_arm, ctrl_abort, sw_trig, ext_trig, trig_sel, din_valid;
  logic [15:0] delay;
  logic [31:0] din;
  logic [31:0] snap_out, status, snap_sat, status_sat;
  logic        capture_pulse, pulse_sat;

  always #5 clk = ~clk;

  snap_val_capture_ctrl dut (
    .user_clk     (clk),
    .user_rst_n   (user_rst_n),
    .ctrl_arm     (ctrl_arm),
    .ctrl_abort   (ctrl_abort),
    .sw_trig      (sw_trig),
    .ext_trig     (ext_trig),
    .trig_sel     (trig_sel),
    .delay        (delay),
    .din          (din),
    .din_valid    (din_valid),
    .snap_out     (snap_out),
    .status       (status),
    .capture_pulse(capture_pulse)
  );

  snap_val_capture_ctrl #(.COUNT_WIDTH(2)) dut_sat (
    .user_clk     (clk),
    .user_rst_n   (user_rst_n),
    .ctrl_arm     (ctrl_arm),
    .ctrl_abort   (ctrl_abort),
    .sw_trig      (sw_trig),
    .ext_trig     (ext_trig),
    .trig_sel     (trig_sel),
    .delay        (delay),
    .din          (din),
    .din_valid    (din_valid),
    .snap_out     (snap_sat),
    .status       (status_sat),
    .capture_pulse(pulse_sat)
  );

  typedef struct {
    logic [31:0] snap;
    logic [31:0] st;
    logic [31:0] st_sat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: mode 0 idle, 1 armed, 2 skipping, 3 done.
  int          m_mode, m_skip, m_count, m_count_sat;
  bit          m_done, m_missed;
  logic [31:0] m_snap;
  bit          p_arm, p_sw, p_ext;

  function automatic logic [31:0] mk_status(input int st, input bit dn, input bit ms,
                                            input int cnt);
    logic [1:0]  s2;
    logic [15:0] c16;
    s2  = st[1:0];
    c16 = cnt[15:0];
    return {s2, dn, ms, 12'b0, c16};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_skip = 0; m_count = 0; m_count_sat = 0;
    m_done = 0; m_missed = 0; m_snap = '0;
    p_arm = 0; p_sw = 0; p_ext = 0;
    sb_q.delete();
  endtask

  // Applies the capture rules to the inputs seen at this clock edge.
  task automatic model_step();
    bit arm_r, trig, win, cap;
    if (!user_rst_n) return;
    arm_r = ctrl_arm && !p_arm;
    trig  = trig_sel ? (ext_trig && !p_ext) : (sw_trig && !p_sw);
    win   = 0;
    cap   = 0;
    if (ctrl_abort) begin
      m_mode = 0;
    end else if (m_mode == 0 || m_mode == 3) begin
      if (arm_r) begin
        m_mode = 1; m_done = 0; m_missed = 0;
      end
    end else if (m_mode == 1) begin
      if (trig) begin
        m_skip = int'(delay); m_mode = 2; win = 1;
      end
    end else begin
      if (trig) m_missed = 1;
      win = 1;
    end
    if (win && din_valid) begin
      if (m_skip == 0) cap = 1;
      else m_skip--;
    end
    if (cap) begin
      m_snap = din; m_done = 1; m_mode = 3;
      if (m_count < 65535) m_count++;
      if (m_count_sat < 3) m_count_sat++;
      sb_q.push_back('{m_snap, mk_status(m_mode, m_done, m_missed, m_count),
                       mk_status(m_mode, m_done, m_missed, m_count_sat)});
    end
    p_arm = ctrl_arm; p_sw = sw_trig; p_ext = ext_trig;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic arm();
    ctrl_arm = 1'b1;
    tick();
    ctrl_arm = 1'b0;
  endtask

  // Monitor: every cycle compare status/snap against the model; on each strobe pop one
  // scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    check("status", 64'(status), 64'(mk_status(m_mode, m_done, m_missed, m_count)));
    check("snap_out", 64'(snap_out), 64'(m_snap));
    if (capture_pulse || sb_q.size() != 0) begin
      check("capture_pulse", 64'(capture_pulse), 64'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        if (capture_pulse) begin
          check("sb_snap", 64'(snap_out), 64'(e.snap));
          check("sb_status", 64'(status), 64'(e.st));
          check("sb_pulse_sat", 64'(pulse_sat), 64'(1));
          check("sb_snap_sat", 64'(snap_sat), 64'(e.snap));
          check("sb_status_sat", 64'(status_sat), 64'(e.st_sat));
        end
      end
    end
  end

  initial begin
    user_rst_n = 1'b0;
    ctrl_arm = 0; ctrl_abort = 0; sw_trig = 0; ext_trig = 0; trig_sel = 0;
    din_valid = 0; delay = '0; din = '0;
    model_reset();
    #3;
    check("reset_snap", 64'(snap_out), 64'(0));
    check("reset_status", 64'(status), 64'(0));
    check("reset_pulse", 64'(capture_pulse), 64'(0));
    @(posedge clk);
    #1 user_rst_n = 1'b1;

    // Immediate capture with delay 0.
    arm();
    delay = 16'd0; din = 32'hA5A5_0001; din_valid = 1; sw_trig = 1;
    tick();
    sw_trig = 0; din_valid = 0;
    check("t1_snap", 64'(snap_out), 64'h0000_0000_A5A5_0001);
    check("t1_status", 64'(status), 64'h0000_0000_E000_0001);
    check("t1_pulse", 64'(capture_pulse), 64'(1));
    tick();
    check("t1_pulse_off", 64'(capture_pulse), 64'(0));

    // delay 3 with continuous valid samples.
    arm();
    delay = 16'd3; din_valid = 1; sw_trig = 1;
    for (int i = 0; i < 4; i++) begin
      din = 32'h10 + 32'(i);
      tick();
      sw_trig = 0;
    end
    din_valid = 0;
    check("t2_snap", 64'(snap_out), 64'h13);
    check("t2_state", 64'(status[31:30]), 64'(3));

    // delay 2 with gapped valids and a retrigger during the window.
    arm();
    delay = 16'd2;
    for (int i = 0; i < 5; i++) begin
      din = 32'h20 + 32'(i);
      din_valid = (i % 2 == 0);
      sw_trig = (i == 0 || i == 2);
      tick();
    end
    sw_trig = 0; din_valid = 0;
    check("t3_snap", 64'(snap_out), 64'h24);
    check("t3_missed", 64'(status[28]), 64'(1));

    // External trigger selected: software trigger must be ignored.
    arm();
    trig_sel = 1; sw_trig = 1;
    tick();
    sw_trig = 0;
    tick();
    check("t4_still_armed", 64'(status[31:30]), 64'(1));
    ext_trig = 1; delay = 16'd1; din_valid = 1; din = 32'h30;
    tick();
    ext_trig = 0; din = 32'h31;
    tick();
    din_valid = 0; trig_sel = 0;
    check("t4_snap", 64'(snap_out), 64'h31);

    // Abort exactly on the capture cycle, then recapture.
    arm();
    delay = 16'd1; din_valid = 1; din = 32'h40; sw_trig = 1;
    tick();
    sw_trig = 0; din = 32'h41; ctrl_abort = 1;
    tick();
    ctrl_abort = 0; din_valid = 0;
    check("t5_idle", 64'(status[31:30]), 64'(0));
    check("t5_snap_kept", 64'(snap_out), 64'h31);
    check("t5_count_kept", 64'(status[15:0]), 64'(4));
    arm();
    delay = 16'd0; din_valid = 1; din = 32'h50; sw_trig = 1;
    tick();
    sw_trig = 0; din_valid = 0;
    check("t5_recapture", 64'(snap_out), 64'h50);
    tick();
    check("t6_sat_count", 64'(status_sat[15:0]), 64'(3));

    // Asynchronous reset in the middle of a skip window.
    arm();
    delay = 16'd5; din_valid = 1; din = 32'h60; sw_trig = 1;
    tick();
    sw_trig = 0;
    tick();
    #2 user_rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_snap", 64'(snap_out), 64'(0));
    check("rst_mid_status", 64'(status), 64'(0));
    check("rst_mid_pulse", 64'(capture_pulse), 64'(0));
    check("rst_mid_status_sat", 64'(status_sat), 64'(0));
    din_valid = 0;
    tick();
    user_rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ctrl_arm   = ($urandom % 8) == 0;
      ctrl_abort = ($urandom % 40) == 0;
      sw_trig    = ($urandom % 5) == 0;
      ext_trig   = ($urandom % 5) == 0;
      trig_sel   = $urandom % 2;
      delay      = 16'($urandom % 6);
      din        = $urandom;
      din_valid  = ($urandom % 3) != 0;
      tick();
    end
    ctrl_arm = 0; ctrl_abort = 0; sw_trig = 0; ext_trig = 0; din_valid = 0;
    tick();
    tick();
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
